// File: rtl/msh_node_rtr.sv
// Five-port mesh router plane: credit-managed input FIFOs, XY routing on the FIFO head,
// per-output round-robin arbitration and registered outputs with per-output credit counters.
module msh_node_rtr #(
  parameter int DW        = 64,
  parameter int RW        = 4,
  parameter int CW        = 4,
  parameter int DEPTH     = 4,
  parameter int CRDT_INIT = 4,
  parameter int CNTW      = $clog2(CRDT_INIT + 1)
) (
  input  logic              mclk,
  input  logic              i_reset_n,
  input  logic [RW-1:0]     i_my_row,
  input  logic [CW-1:0]     i_my_col,
  input  logic [4:0]        i_vld,
  input  logic [5*DW-1:0]   i_data,
  input  logic [5*RW-1:0]   i_dst_row,
  input  logic [5*CW-1:0]   i_dst_col,
  output logic [4:0]        o_crdt_rtn,
  output logic [4:0]        o_vld,
  output logic [5*DW-1:0]   o_data,
  output logic [5*RW-1:0]   o_dst_row,
  output logic [5*CW-1:0]   o_dst_col,
  input  logic [4:0]        i_crdt_rtn,
  output logic [4:0]        o_ovfl,
  output logic [4:0]        o_crdt_err
);
  // Handshake: no ready signal in either direction. A sender may raise i_vld[p] only while it
  // holds a credit for this FIFO; each pop returns one credit on o_crdt_rtn[p]. Downstream, a
  // grant consumes one credit of cred_q[o] and i_crdt_rtn[o] gives one back.
  localparam int NP = 5;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = DW + RW + CW;
  localparam logic [2:0] P_N = 3'd0, P_S = 3'd1, P_E = 3'd2, P_W = 3'd3, P_L = 3'd4;
  localparam logic [CNTW-1:0] CRDT_MAX = CNTW'(CRDT_INIT);
  localparam logic [CNTW-1:0] CRDT_ONE = CNTW'(1);

  logic [EW-1:0]   mem_q    [NP][DEPTH];
  logic [AW:0]     wr_ptr_q [NP];
  logic [AW:0]     rd_ptr_q [NP];
  logic [CNTW-1:0] cred_q   [NP];
  logic [2:0]      rr_q     [NP];
  logic [NP-1:0]   vld_q, crdt_rtn_q, ovfl_q, crdt_err_q;
  logic [5*DW-1:0] data_q;
  logic [5*RW-1:0] dst_row_q;
  logic [5*CW-1:0] dst_col_q;

  logic [NP-1:0]   empty, full, push, pop, gnt_any;
  logic [EW-1:0]   head    [NP];
  logic [2:0]      route   [NP];
  logic [NP-1:0]   req     [NP];
  logic [NP-1:0]   gnt     [NP];
  logic [2:0]      gnt_src [NP];
  logic [EW-1:0]   out_ent [NP];

  // Pointer layout is {wrap, index}; the index wraps at DEPTH so DEPTH need not be a power of 2.
  function automatic logic [AW:0] ptr_inc(input logic [AW:0] ptr);
    if (ptr[AW-1:0] == AW'(DEPTH - 1)) return {~ptr[AW], {AW{1'b0}}};
    return ptr + 1'b1;
  endfunction

  function automatic logic [2:0] rr_idx(input logic [2:0] base, input int k);
    logic [3:0] s;
    s = {1'b0, base} + 4'(k);
    return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      empty[p] = (wr_ptr_q[p] == rd_ptr_q[p]);
      full[p]  = (wr_ptr_q[p][AW-1:0] == rd_ptr_q[p][AW-1:0]) &&
                 (wr_ptr_q[p][AW] != rd_ptr_q[p][AW]);
      push[p]  = i_vld[p] && !full[p];
      head[p]  = mem_q[p][rd_ptr_q[p][AW-1:0]];
      route[p] = P_L;
      if (head[p][CW-1:0] > i_my_col)         route[p] = P_E;
      else if (head[p][CW-1:0] < i_my_col)    route[p] = P_W;
      else if (head[p][CW +: RW] > i_my_row)  route[p] = P_S;
      else if (head[p][CW +: RW] < i_my_row)  route[p] = P_N;
    end
  end

  always_comb begin
    pop = '0;
    for (int o = 0; o < NP; o++) begin
      req[o]     = '0;
      gnt[o]     = '0;
      gnt_any[o] = 1'b0;
      gnt_src[o] = '0;
      out_ent[o] = '0;
      for (int i = 0; i < NP; i++)
        req[o][i] = !empty[i] && (route[i] == 3'(o)) && (cred_q[o] != '0);
      for (int k = 0; k < NP; k++) begin
        if (!gnt_any[o] && req[o][rr_idx(rr_q[o], k)]) begin
          gnt_any[o] = 1'b1;
          gnt_src[o] = rr_idx(rr_q[o], k);
          gnt[o][rr_idx(rr_q[o], k)] = 1'b1;
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (gnt[o][i]) out_ent[o] = head[i];
      end
      pop = pop | gnt[o];
    end
  end

  // Storage is not reset; only the pointers define FIFO contents.
  always_ff @(posedge mclk) begin
    for (int p = 0; p < NP; p++) begin
      if (push[p])
        mem_q[p][wr_ptr_q[p][AW-1:0]] <= {i_data[p*DW +: DW], i_dst_row[p*RW +: RW],
                                          i_dst_col[p*CW +: CW]};
    end
  end

  always_ff @(posedge mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int p = 0; p < NP; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cred_q[p]   <= CRDT_MAX;
        rr_q[p]     <= '0;
      end
      vld_q      <= '0;
      crdt_rtn_q <= '0;
      ovfl_q     <= '0;
      crdt_err_q <= '0;
      data_q     <= '0;
      dst_row_q  <= '0;
      dst_col_q  <= '0;
    end else begin
      crdt_rtn_q <= pop;
      ovfl_q     <= ovfl_q | (i_vld & full);
      for (int p = 0; p < NP; p++) begin
        if (push[p]) wr_ptr_q[p] <= ptr_inc(wr_ptr_q[p]);
        if (pop[p])  rd_ptr_q[p] <= ptr_inc(rd_ptr_q[p]);
      end
      for (int o = 0; o < NP; o++) begin
        vld_q[o] <= gnt_any[o];
        if (gnt_any[o]) begin
          data_q[o*DW +: DW]    <= out_ent[o][EW-1 -: DW];
          dst_row_q[o*RW +: RW] <= out_ent[o][CW +: RW];
          dst_col_q[o*CW +: CW] <= out_ent[o][CW-1:0];
          rr_q[o]               <= rr_idx(gnt_src[o], 1);
        end
        // A grant and a return in the same cycle cancel out.
        case ({gnt_any[o], i_crdt_rtn[o]})
          2'b10:   cred_q[o] <= cred_q[o] - CRDT_ONE;
          2'b01: begin
            if (cred_q[o] == CRDT_MAX) crdt_err_q[o] <= 1'b1;
            else                       cred_q[o]     <= cred_q[o] + CRDT_ONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_vld      = vld_q;
  assign o_crdt_rtn = crdt_rtn_q;
  assign o_data     = data_q;
  assign o_dst_row  = dst_row_q;
  assign o_dst_col  = dst_col_q;
  assign o_ovfl     = ovfl_q;
  assign o_crdt_err = crdt_err_q;

endmodule

// File: tb/tb_msh_node_rtr.sv
// Directed bench for msh_node_rtr: local delivery, XY routing, round-robin, credit backpressure,
// overflow / credit error and asynchronous reset mid-stream.
`timescale 1ns/1ps
module tb_msh_node_rtr;
  localparam int DW = 64, RW = 4, CW = 4, DEPTH = 4, CRDT_INIT = 4;
  localparam int PN = 0, PS = 1, PE = 2, PW = 3, PL = 4;

  logic            mclk = 1'b0;
  logic            i_reset_n = 1'b0;
  logic [RW-1:0]   i_my_row = 4'd2;
  logic [CW-1:0]   i_my_col = 4'd2;
  logic [4:0]      i_vld = '0;
  logic [5*DW-1:0] i_data = '0;
  logic [5*RW-1:0] i_dst_row = '0;
  logic [5*CW-1:0] i_dst_col = '0;
  logic [4:0]      i_crdt_rtn = '0;
  logic [4:0]      o_crdt_rtn, o_vld, o_ovfl, o_crdt_err;
  logic [5*DW-1:0] o_data;
  logic [5*RW-1:0] o_dst_row;
  logic [5*CW-1:0] o_dst_col;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  msh_node_rtr #(.DW(DW), .RW(RW), .CW(CW), .DEPTH(DEPTH), .CRDT_INIT(CRDT_INIT)) dut (
    .mclk(mclk), .i_reset_n(i_reset_n), .i_my_row(i_my_row), .i_my_col(i_my_col),
    .i_vld(i_vld), .i_data(i_data), .i_dst_row(i_dst_row), .i_dst_col(i_dst_col),
    .o_crdt_rtn(o_crdt_rtn), .o_vld(o_vld), .o_data(o_data), .o_dst_row(o_dst_row),
    .o_dst_col(o_dst_col), .i_crdt_rtn(i_crdt_rtn), .o_ovfl(o_ovfl), .o_crdt_err(o_crdt_err)
  );

  // clock / reset
  always #5 mclk = ~mclk;

  task automatic tick;
    @(posedge mclk);
    #1;
  endtask

  task automatic do_reset;
    i_vld = '0;
    i_crdt_rtn = '0;
    #2 i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic send(input int p, input logic [63:0] d, input logic [3:0] r,
                      input logic [3:0] c);
    i_vld[p] = 1'b1;
    i_data[p*DW +: DW] = d;
    i_dst_row[p*RW +: RW] = r;
    i_dst_col[p*CW +: CW] = c;
  endtask

  function automatic logic [63:0] out_data(input int p);
    return o_data[p*DW +: DW];
  endfunction

  function automatic int model_route(input logic [3:0] r, input logic [3:0] c);
    if (c > i_my_col) return PE;
    if (c < i_my_col) return PW;
    if (r > i_my_row) return PS;
    if (r < i_my_row) return PN;
    return PL;
  endfunction

  // Stimulus must never steer a packet back out of its arrival port.
  always @(negedge mclk) begin
    if (i_reset_n) begin
      for (int p = 0; p < 4; p++) begin
        if (i_vld[p])
          assert (model_route(i_dst_row[p*RW +: RW], i_dst_col[p*CW +: CW]) != p)
            else $error("u-turn stimulus on port %0d", p);
      end
    end
  end

  // N, S and W each stream 4 packets to E; E credits returned on every grant cycle.
  task automatic rr_stream(input int last_k);
    int src[3] = '{PN, PS, PW};
    exp_q.delete();
    for (int s = 0; s < 4; s++)
      for (int j = 0; j < 3; j++) exp_q.push_back(64'((src[j] << 8) | s));
    for (int k = 0; k <= last_k; k++) begin
      i_vld = '0;
      i_crdt_rtn = '0;
      if (k >= 2 && k <= 13) begin
        chk("t3_vld", 64'(o_vld), 64'(5'b00100));
        chk("t3_order", out_data(PE), exp_q.pop_front());
      end
      if (k == 14) chk("t3_idle", 64'(o_vld), 64'd0);
      if (k < 4)
        for (int j = 0; j < 3; j++) send(src[j], 64'((src[j] << 8) | k), 4'd2, 4'd5);
      if (k >= 1 && k <= 12) i_crdt_rtn[PE] = 1'b1;
      if (k < last_k) tick();
    end
  endtask

  initial begin
    logic [3:0] t2_row[4] = '{4'd0, 4'd0, 4'd3, 4'd3};
    logic [3:0] t2_col[4] = '{4'd5, 4'd2, 4'd1, 4'd2};
    int         t2_out[4] = '{PE, PN, PW, PS};
    int cnt;

    tick();
    chk("rst_vld", 64'(o_vld), 64'd0);
    chk("rst_data", 64'(|o_data), 64'd0);
    chk("rst_flags", 64'({o_ovfl, o_crdt_err, o_crdt_rtn}), 64'd0);
    tick();
    i_reset_n = 1'b1;

    // 1: local delivery from W, then credit saturation on L
    send(PW, 64'hA5, 4'd2, 4'd2);
    tick();
    i_vld = '0;
    chk("t1_early", 64'(o_vld), 64'd0);
    tick();
    chk("t1_vld", 64'(o_vld), 64'(5'b10000));
    chk("t1_data", out_data(PL), 64'hA5);
    chk("t1_crdt_rtn", 64'(o_crdt_rtn), 64'(5'b01000));
    chk("t1_dst", 64'({o_dst_row[PL*RW +: RW], o_dst_col[PL*CW +: CW]}), 64'h22);
    tick();
    chk("t1_vld_clr", 64'(o_vld), 64'd0);
    chk("t1_rtn_clr", 64'(o_crdt_rtn), 64'd0);
    chk("t1_data_hold", out_data(PL), 64'hA5);
    i_crdt_rtn[PL] = 1'b1;
    tick();
    i_crdt_rtn = '0;
    chk("t1_rtn_ok", 64'(o_crdt_err), 64'd0);
    i_crdt_rtn[PL] = 1'b1;
    tick();
    i_crdt_rtn = '0;
    chk("t1_rtn_sat", 64'(o_crdt_err), 64'(5'b10000));
    do_reset();

    // 2: XY order from L
    for (int v = 0; v < 4; v++) begin
      send(PL, 64'(16'hB0 + v), t2_row[v], t2_col[v]);
      tick();
      i_vld = '0;
      tick();
      chk("t2_port", 64'(o_vld), 64'(5'(1 << t2_out[v])));
      chk("t2_data", out_data(t2_out[v]), 64'(16'hB0 + v));
      chk("t2_dst_col", 64'(o_dst_col[t2_out[v]*CW +: CW]), 64'(t2_col[v]));
      tick();
    end
    do_reset();

    // 3: round-robin into E
    rr_stream(14);
    i_vld = '0;
    i_crdt_rtn = '0;
    chk("t3_no_err", 64'(o_crdt_err), 64'd0);
    do_reset();

    // 4: credit backpressure, 6 packets to E with no returns
    exp_q.delete();
    for (int s = 0; s < 6; s++) exp_q.push_back(64'(s));
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      i_vld = '0;
      if (o_vld[PE]) begin
        cnt++;
        chk("t4_data", out_data(PE), exp_q.pop_front());
      end
      if (k < 6) send(PL, 64'(k), 4'd2, 4'd5);
      tick();
    end
    i_vld = '0;
    chk("t4_count", 64'(cnt), 64'd4);
    i_crdt_rtn[PE] = 1'b1;
    tick();
    i_crdt_rtn = '0;
    chk("t4_wait", 64'(o_vld[PE]), 64'd0);
    tick();
    chk("t4_fifth_vld", 64'(o_vld[PE]), 64'd1);
    chk("t4_fifth_data", out_data(PE), 64'd4);
    tick();
    chk("t4_one_only", 64'(o_vld[PE]), 64'd0);
    do_reset();

    // 5: overflow on N with E starved, then credit error on S
    for (int k = 0; k < 9; k++) begin
      i_vld = '0;
      if (k < 4) send(PL, 64'(16'h50 + k), 4'd2, 4'd5);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      i_vld = '0;
      chk("t5_ovfl_pre", 64'(o_ovfl), 64'd0);
      send(PN, 64'(16'h100 + k), 4'd2, 4'd5);
      tick();
    end
    i_vld = '0;
    chk("t5_ovfl", 64'(o_ovfl), 64'(5'b00001));
    tick();
    tick();
    chk("t5_ovfl_sticky", 64'(o_ovfl), 64'(5'b00001));
    exp_q.delete();
    for (int s = 0; s < 4; s++) exp_q.push_back(64'(16'h100 + s));
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      i_crdt_rtn = '0;
      if (o_vld[PE]) begin
        cnt++;
        if (exp_q.size() > 0) chk("t5_data", out_data(PE), exp_q.pop_front());
      end
      if (j < 4) i_crdt_rtn[PE] = 1'b1;
      tick();
    end
    i_crdt_rtn = '0;
    chk("t5_drained", 64'(cnt), 64'd4);
    chk("t5_err_pre", 64'(o_crdt_err), 64'd0);
    i_crdt_rtn[PS] = 1'b1;
    tick();
    i_crdt_rtn = '0;
    chk("t5_crdt_err", 64'(o_crdt_err), 64'(5'b00010));
    tick();
    chk("t5_err_sticky", 64'(o_crdt_err), 64'(5'b00010));
    do_reset();

    // 6: asynchronous reset in the middle of the round-robin stream
    rr_stream(6);
    #3 i_reset_n = 1'b0;
    i_vld = '0;
    i_crdt_rtn = '0;
    #1;
    chk("t6_vld", 64'(o_vld), 64'd0);
    chk("t6_rtn", 64'(o_crdt_rtn), 64'd0);
    chk("t6_data", 64'(|o_data), 64'd0);
    chk("t6_dst", 64'(|{o_dst_row, o_dst_col}), 64'd0);
    chk("t6_flags", 64'({o_ovfl, o_crdt_err}), 64'd0);
    tick();
    i_reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      i_vld = '0;
      if (k == 1) chk("t6_early", 64'(o_vld), 64'd0);
      if (k == 2) begin
        chk("t6_lat_vld", 64'(o_vld), 64'(5'b00100));
        chk("t6_lat_data", out_data(PE), 64'h600);
      end
      if (o_vld[PE]) cnt++;
      if (k < 5) send(PL, 64'(16'h600 + k), 4'd2, 4'd5);
      tick();
    end
    i_vld = '0;
    chk("t6_full_credits", 64'(cnt), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/msh_node_rtr.md
# msh_node_rtr

Single-plane, parametrised mesh node router for the next-generation mesh; the node top instantiates one per plane. Each instance has five ports: north, south, east, west and local. Every input port has a credit-managed FIFO. Packets are steered with dimension-ordered (XY) routing against strapped node coordinates, and each output port uses round-robin arbitration. Each output port also keeps a credit counter toward its downstream neighbour.

## Interface
Port index p: 0=N, 1=S, 2=E, 3=W, 4=local (L). Vectors are packed with port 0 in the LSBs.

Parameters:
- DW, 64, payload width.
- RW, 4, row coordinate width.
- CW, 4, column coordinate width.
- DEPTH, 4, input FIFO entries per port (≥2).
- CRDT_INIT, 4, reset credit count per output; equals the downstream DEPTH.
- CNTW, $clog2(CRDT_INIT+1), credit counter width.

Ports:
- mclk  in  1  mesh clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_my_row  in  RW  strapped node row (quasi-static)
- i_my_col  in  CW  strapped node column (quasi-static)
- i_vld  in  5  input packet valid per port
- i_data  in  5*DW  input payload
- i_dst_row  in  5*RW  input destination row
- i_dst_col  in  5*CW  input destination column
- o_crdt_rtn  out  5  one credit returned to the upstream sender per FIFO pop
- o_vld  out  5  output packet valid per port
- o_data  out  5*DW  output payload
- o_dst_row  out  5*RW  output destination row (passed through)
- o_dst_col  out  5*CW  output destination column (passed through)
- i_crdt_rtn  in  5  one credit returned by the downstream receiver
- o_ovfl  out  5  sticky: write arrived while the input FIFO was full
- o_crdt_err  out  5  sticky: credit return arrived while the counter was at CRDT_INIT

## Operation
- **Input FIFO:** one per port, DEPTH entries. Each entry holds {data, dst_row, dst_col}.
  - Write when i_vld[p] is high.
  - If the FIFO is full, drop the write and set o_ovfl[p]; the FIFO is unchanged.
- **Routing:** computed combinationally on the FIFO head, in this priority order.
  - dst_col > my_col → E.
  - dst_col < my_col → W.
  - Otherwise dst_row > my_row → S (rows grow southward).
  - Otherwise dst_row < my_row → N.
  - Otherwise → L.
- **Credit counter:** one per output, cred[o], reset to CRDT_INIT.
  - Decrement on a grant to output o.
  - Increment on i_crdt_rtn[o].
  - Grant and return in the same cycle: value unchanged.
  - Return while cred == CRDT_INIT and no grant that cycle: saturate and set o_crdt_err[o].
- **Arbitration:** per output, round-robin over the 5 inputs whose non-empty head routes to that output.
  - Eligible only if cred[o] > 0.
  - The search starts at rr[o]. After a grant to input i, rr[o] = (i+1) mod 5; with no grant, rr[o] is unchanged.
  - Each head routes to exactly one output, so an input receives at most one grant per cycle.
- **U-turn:** a head routing back out of its own arrival port (p≠L) is still routed normally. The bench asserts this never occurs.
- **Granted packet:** popped from its FIFO and loaded into the output register of its output port. o_crdt_rtn[i] pulses for one cycle.
- **Output register:** loaded on a grant. Otherwise o_vld is cleared; data fields hold their last value.
- **Reset:** asynchronous assertion at any time clears everything immediately. This includes FIFOs empty, in-flight output registers discarded, cred = CRDT_INIT, rr = 0, and sticky flags cleared. Credits already in flight are not reconciled; the whole mesh resets together.
- **Reset values of outputs:** o_vld=0, o_crdt_rtn=0, o_data=0, o_dst_row=0, o_dst_col=0, o_ovfl=0, o_crdt_err=0.

## Timing
- Input sampled at edge E0 and written to the FIFO. The head is visible in the following cycle, and arbitration is combinational.
- At E1 the output register loads and o_crdt_rtn registers. Minimum latency is i_vld in cycle 0 → o_vld in cycle 2.
- Throughput: 1 packet per cycle per output and per input, given credits.
- FIFO simultaneous push and pop when full:
  - The pop frees the slot only at the edge, so the push is dropped and o_ovfl is set.
  - With correct credit usage, upstream never does this.
- FIFO simultaneous push and pop when empty: the push is written; the head is visible next cycle (no bypass).
- A credit returned in cycle t is usable for a grant in cycle t+1.
- Pointers wrap modulo DEPTH; full/empty are tracked with an extra wrap bit.
- First cycle after reset deassertion: i_vld is honoured.

## Test plan
1. **Local delivery.** my=(2,2), single packet on W with dst=(2,2), data=0xA5 in cycle 0 → o_vld[L]=1 with data 0xA5 in cycle 2; o_crdt_rtn[W]=1 in cycle 2; cred[L]=3 until i_crdt_rtn[L].
2. **XY order.**
   - my=(2,2), dst=(0,5) on L → exits E.
   - dst=(0,2) → exits N.
   - dst=(3,1) → exits W.
3. **Round-robin.** N, S and W each stream 4 packets to E, with i_crdt_rtn[E] tied high → E output order N,S,W,N,S,W,… with no idle cycles; 12 packets in 12 consecutive cycles.
4. **Credit backpressure.** CRDT_INIT=4, 6 packets to E, no credit returns → exactly 4 emerge; the 5th appears 2 cycles after a single i_crdt_rtn[E] pulse.
5. **Overflow and credit error.**
   - Stall output E with no credits, then push DEPTH+1=5 packets on N → 5th dropped, o_ovfl[N]=1 sticky.
   - i_crdt_rtn[S] with cred[S]=4 → o_crdt_err[S]=1.
6. **Async reset mid-stream.** Assert i_reset_n=0 mid-cycle during test 3 → all outputs 0 immediately; after release, a new packet traverses with 2-cycle latency and full CRDT_INIT credits.
